bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter, the inverse of the team's binary-to-BCD converter. It takes a packed multi-digit BCD value and produces the equivalent unsigned binary number. It uses one multiply-by-10-and-add step per clock, most-significant digit first. It sits between BCD entry sources (switch banks, keypad digit registers) and binary arithmetic or timer-load logic, using a start/busy/done handshake.

Parameters:
DIGITS, 3, number of BCD digits in bcd_in (1..4)
OUT_W, 10, width of bin_out; must satisfy 2^OUT_W > 10^DIGITS - 1 (3 digits -> 10, 4 digits -> 14)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a conversion; sampled only in IDLE
bcd_in  input  4*DIGITS  packed BCD, digit DIGITS-1 (most significant) in the top nibble
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bin_out/err are updated
err  output  1  high with done if any digit of the latched value was > 9; holds until next accepted start
bin_out  output  OUT_W  converted binary value; holds until the next done

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset (rst_n low, immediate): state = IDLE; busy = 0; done = 0; err = 0; bin_out = 0; internal accumulator, shift register and digit counter = 0.
- FSM states: IDLE, CONV, FIN.
- IDLE -> CONV at an edge with start = 1:
  - bcd_in latched into shift register; accumulator = 0; digit counter = DIGITS; error flag = 0.
  - err output cleared; busy = 1 from this edge.
- start = 0 in IDLE: stay in IDLE.
- CONV, each edge:
  - d = top nibble of the shift register.
  - acc <= (acc << 3) + (acc << 1) + d, truncated to OUT_W bits.
  - Shift register shifts left 4 bits, zero fill.
  - If d > 9, the internal error flag sets (sticky for this conversion).
  - Counter decrements.
- CONV -> FIN at the edge that processes the last digit (counter == 1):
  - At that same edge: done = 1, busy = 0.
  - bin_out = computed value if no error, otherwise bin_out = 0.
  - err = error flag.
- FIN -> IDLE unconditionally at the next edge; done returns to 0.
- Latency: with start accepted at edge E0, done is high for exactly the cycle following edge E0+DIGITS. busy is high for cycles E0..E0+DIGITS-1.
- The next start can be accepted at edge E0+DIGITS+2 (first IDLE edge). Throughput is one conversion per DIGITS+2 cycles.
- start while in CONV or FIN is ignored, with no queuing. bcd_in changes after the accepting edge have no effect.
- Invalid digits (A-F) do not abort the conversion: processing still takes DIGITS cycles, then err = 1 and bin_out = 0.
- Valid-input arithmetic never overflows under the OUT_W rule. The truncation applies only to invalid-digit paths, whose result is discarded anyway.
- Reset asserted mid-conversion: the conversion is aborted, no done pulse is produced, and all outputs return to reset values.
- bin_out and err change only at a done edge or at reset.

Test Plan:
- Reset, then start with bcd_in = 12'h999 -> busy high 3 cycles; done pulses in the 4th cycle after the start edge; bin_out = 10'd999 (0x3E7); err = 0.
- bcd_in = 12'h255 -> bin_out = 255. Then back-to-back start (asserted continuously) with 12'h000 -> second conversion accepted at the first IDLE edge (E0+5); bin_out = 0; done pulses exactly once per conversion.
- bcd_in = 12'h1A3 -> done after 3 cycles; err = 1; bin_out = 0. A following start with 12'h042 -> err clears at the accepting edge; bin_out = 42; err = 0.
- Pulse start with 12'h123, then assert start with 12'h456 during CONV and during FIN -> only one done; bin_out = 123; no second conversion until start is reasserted in IDLE.
- Start with 12'h777, assert rst_n low one cycle later (asynchronously, mid-cycle) -> busy, done, err and bin_out go to 0 immediately; after release, no done pulse appears; a fresh start with 12'h010 yields bin_out = 10.
- DIGITS = 4, OUT_W = 14 build: bcd_in = 16'h9999 -> bin_out = 9999 after 4 conversion cycles; 16'h0001 -> bin_out = 1.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Packed-BCD to unsigned binary converter, one multiply-by-10-and-add step per clock, MSD first.
// Latency: done pulses in the cycle after edge E0+DIGITS, where E0 is the accepting edge.
// Backpressure: start is taken only in IDLE; starts during CONV or FIN are dropped, not queued.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [OUT_W-1:0]      bin_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   sreg, sreg_nxt;
    logic [OUT_W-1:0]   acc, acc_nxt, acc_step;
    logic [OUT_W-1:0]   bin_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_flag, err_flag_nxt;
    logic               err_nxt;
    logic [3:0]         dig;
    logic               dig_bad;

    assign dig      = sreg[BCD_W-1 -: 4];
    assign dig_bad  = (dig > 4'd9);
    // acc*10 + d as two shifts; truncation only matters on invalid-digit paths
    assign acc_step = (acc << 3) + (acc << 1) + OUT_W'(dig);

    assign busy = (state == CONV);
    assign done = (state == FIN);

    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        err_flag_nxt = err_flag;
        err_nxt      = err;
        bin_nxt      = bin_out;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = CONV;
                    sreg_nxt     = bcd_in;
                    acc_nxt      = '0;
                    cnt_nxt      = CNT_W'(DIGITS);
                    err_flag_nxt = 1'b0;
                    err_nxt      = 1'b0;
                end
            end
            CONV: begin
                acc_nxt      = acc_step;
                sreg_nxt     = sreg << 4;
                err_flag_nxt = err_flag | dig_bad;
                cnt_nxt      = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    // Last digit: publish result, including this digit's validity
                    state_nxt = FIN;
                    err_nxt   = err_flag | dig_bad;
                    bin_nxt   = (err_flag | dig_bad) ? '0 : acc_step;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            err      <= 1'b0;
            bin_out  <= '0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            err_flag <= err_flag_nxt;
            err      <= err_nxt;
            bin_out  <= bin_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: a 3-digit and a 4-digit instance sharing clock and reset.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;

    logic        start3;
    logic [11:0] bcd3;
    logic        busy3, done3, err3;
    logic [9:0]  bin3;

    logic        start4;
    logic [15:0] bcd4;
    logic        busy4, done4, err4;
    logic [13:0] bin4;

    int n_tests;
    int n_fail;

    bcd_to_bin_seq #(.DIGITS(3), .OUT_W(10)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start3),
        .bcd_in  (bcd3),
        .busy    (busy3),
        .done    (done3),
        .err     (err3),
        .bin_out (bin3)
    );

    bcd_to_bin_seq #(.DIGITS(4), .OUT_W(14)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .bcd_in  (bcd4),
        .busy    (busy4),
        .done    (done4),
        .err     (err4),
        .bin_out (bin4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full conversion on the selected instance (0: 3-digit, 1: 4-digit).
    // bcd_in is scrambled after the accepting edge to show it is no longer looked at.
    task automatic conv(input int sel, input logic [15:0] v, input int exp_bin,
                        input logic exp_err, input string tag);
        int nd;
        nd = (sel != 0) ? 4 : 3;
        @(negedge clk);
        if (sel != 0) begin start4 = 1'b1; bcd4 = v; end
        else          begin start3 = 1'b1; bcd3 = v[11:0]; end
        @(negedge clk);
        start3 = 1'b0;
        start4 = 1'b0;
        bcd3   = 12'hFFF;
        bcd4   = 16'hFFFF;
        for (int i = 0; i < nd; i++) begin
            check({tag, "_busy"}, 32'((sel != 0) ? busy4 : busy3), 32'd1);
            check({tag, "_err_clr"}, 32'((sel != 0) ? err4 : err3), 32'd0);
            @(negedge clk);
        end
        check({tag, "_done"}, 32'((sel != 0) ? done4 : done3), 32'd1);
        check({tag, "_busy_end"}, 32'((sel != 0) ? busy4 : busy3), 32'd0);
        check({tag, "_bin"}, (sel != 0) ? 32'(bin4) : 32'(bin3), 32'(exp_bin));
        check({tag, "_err"}, 32'((sel != 0) ? err4 : err3), 32'(exp_err));
        @(negedge clk);
        check({tag, "_done_drop"}, 32'((sel != 0) ? done4 : done3), 32'd0);
    endtask

    initial begin
        logic [10:0] bp, dp;
        int          cnt_done, cnt_busy;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start3  = 1'b0;
        start4  = 1'b0;
        bcd3    = '0;
        bcd4    = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_done", 32'(done3), 32'd0);
        check("rst_err",  32'(err3),  32'd0);
        check("rst_bin",  32'(bin3),  32'd0);
        check("rst_bin4", 32'(bin4),  32'd0);
        rst_n = 1'b1;

        conv(0, 16'h0999, 999, 1'b0, "c999");
        conv(0, 16'h0255, 255, 1'b0, "c255");

        // start held high: second conversion is accepted at E0+5
        @(negedge clk);
        start3 = 1'b1;
        bcd3   = 12'h000;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            bp[c] = busy3;
            dp[c] = done3;
            if (c == 5) start3 = 1'b0;
        end
        check("b2b_busy_pat", 32'(bp), 32'h0E7);
        check("b2b_done_pat", 32'(dp), 32'h108);
        check("b2b_bin", 32'(bin3), 32'd0);

        conv(0, 16'h01A3, 0, 1'b1, "c1A3");
        conv(0, 16'h0042, 42, 1'b0, "c042");

        // starts during CONV and FIN are dropped
        @(negedge clk);
        start3 = 1'b1;
        bcd3   = 12'h123;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bp[c] = busy3;
            dp[c] = done3;
            start3 = (c == 1 || c == 3);
            bcd3   = 12'h456;
        end
        start3 = 1'b0;
        check("ign_busy_pat", 32'(bp[8:0]), 32'h007);
        check("ign_done_pat", 32'(dp[8:0]), 32'h008);
        check("ign_bin", 32'(bin3), 32'd123);

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        start3 = 1'b1;
        bcd3   = 12'h777;
        @(negedge clk);
        start3 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy3), 32'd0);
        check("arst_done", 32'(done3), 32'd0);
        check("arst_err",  32'(err3),  32'd0);
        check("arst_bin",  32'(bin3),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_done = 0;
        cnt_busy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done3) cnt_done++;
            if (busy3) cnt_busy++;
        end
        check("arst_no_done", 32'(cnt_done), 32'd0);
        check("arst_no_busy", 32'(cnt_busy), 32'd0);
        conv(0, 16'h0010, 10, 1'b0, "c010");

        conv(1, 16'h9999, 9999, 1'b0, "d9999");
        conv(1, 16'h0001, 1, 1'b0, "d0001");
        conv(1, 16'h90F9, 0, 1'b1, "d90F9");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
